// File: rtl/monitor_pkg.sv
// monitor_pkg: shared types and constants for the monitor source scheduler.
//   MON_DATA_WIDTH  default signed sample width of the monitor path
//   MON_GAIN_BITS   default ramp resolution (full gain = 2^MON_GAIN_BITS)
//   FULL_GAIN       gain value that passes a sample unchanged
//   stereo_sample_t left/right pair in the monitor_controller sample format
//   sched_state_t   scheduler states (MUTE_* only reachable when
//                   MONITOR_SCHEDULER_MUTE_EN is defined)
package monitor_pkg;

    localparam int MON_DATA_WIDTH = 24;
    localparam int MON_GAIN_BITS  = 6;
    localparam int FULL_GAIN      = 1 << MON_GAIN_BITS;

    typedef struct packed {
        logic signed [MON_DATA_WIDTH-1:0] left;
        logic signed [MON_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

    typedef enum logic [2:0] {
        PLAY     = 3'd0,
        FADE_OUT = 3'd1,
        SWAP     = 3'd2,
        FADE_IN  = 3'd3,
        MUTE_OUT = 3'd4,
        MUTED    = 3'd5
    } sched_state_t;

endpackage

// File: rtl/monitor_gain_stage.sv
// monitor_gain_stage: registered signed multiply-and-shift of one stereo
// sample by an unsigned gain in [0, 2^GAIN_BITS], one cycle of latency.
//   clock, reset_n            clock, async active-low reset
//   sample_left/right/valid   input sample and strobe
//   gain                      GAIN_BITS+1 bit gain, 2^GAIN_BITS = unity
//   data_left/right/valid     gained sample; data holds between strobes
module monitor_gain_stage #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_BITS  = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    input  logic                  sample_valid,
    input  logic [GAIN_BITS:0]    gain,
    output logic [DATA_WIDTH-1:0] data_left,
    output logic [DATA_WIDTH-1:0] data_right,
    output logic                  data_valid
);

    // Full-width product so the arithmetic shift floors toward -inf exactly.
    localparam int PW = DATA_WIDTH + GAIN_BITS + 2;

    logic signed [PW-1:0] gain_s;
    logic signed [PW-1:0] prod_left;
    logic signed [PW-1:0] prod_right;

    assign gain_s     = PW'({1'b0, gain});
    assign prod_left  = PW'($signed(sample_left)) * gain_s;
    assign prod_right = PW'($signed(sample_right)) * gain_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_left  <= '0;
            data_right <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= sample_valid;
            if (sample_valid) begin
                data_left  <= DATA_WIDTH'(prod_left >>> GAIN_BITS);
                data_right <= DATA_WIDTH'(prod_right >>> GAIN_BITS);
            end
        end
    end

endmodule

// File: rtl/monitor_source_scheduler.sv
// monitor_source_scheduler: shares the stereo monitor path between
// NUM_SOURCES producers; every source change runs fade-out, swap, fade-in.
// Optional feature macro: MONITOR_SCHEDULER_MUTE_EN (adds i_mute and the
// MUTE_OUT/MUTED states).
//   i_clock, i_reset_n          clock, async active-low reset
//   i_data_left/right/valid     packed per-source samples and strobes
//   i_select, i_select_valid    source request; o_select_ready accepts it
//   o_active_source             source currently routed
//   o_switching                 high whenever not in PLAY
//   o_data_left/right/valid     gained output, one cycle after the sample
//
// state    | meaning
// PLAY     | unity gain, requests accepted
// FADE_OUT | gain steps down per active-source sample
// SWAP     | one cycle, routes the pending source, no output
// FADE_IN  | gain steps up per active-source sample (reset state)
// MUTE_OUT | mute ramp down per sample
// MUTED    | gain 0, zero-data strobes continue
module monitor_source_scheduler
    import monitor_pkg::*;
#(
    parameter  int NUM_SOURCES = 4,
    parameter  int DATA_WIDTH  = MON_DATA_WIDTH,
    parameter  int GAIN_BITS   = MON_GAIN_BITS,
    localparam int SEL_WIDTH   = $clog2(NUM_SOURCES)
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_data_left,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_data_right,
    input  logic [NUM_SOURCES-1:0]            i_data_valid,
    input  logic [SEL_WIDTH-1:0]              i_select,
    input  logic                              i_select_valid,
`ifdef MONITOR_SCHEDULER_MUTE_EN
    input  logic                              i_mute,
`endif
    output logic                              o_select_ready,
    output logic [SEL_WIDTH-1:0]              o_active_source,
    output logic                              o_switching,
    output logic [DATA_WIDTH-1:0]             o_data_left,
    output logic [DATA_WIDTH-1:0]             o_data_right,
    output logic                              o_data_valid
);

    localparam logic [GAIN_BITS:0] GAIN_MAX  = (GAIN_BITS+1)'(1 << GAIN_BITS);
    localparam logic [GAIN_BITS:0] GAIN_ONE  = (GAIN_BITS+1)'(1);
    localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH+1)'(NUM_SOURCES);

    sched_state_t           state;
    logic [GAIN_BITS:0]     gain;
    logic [SEL_WIDTH-1:0]   pending;
    logic                   act_valid;
    logic [DATA_WIDTH-1:0]  act_left;
    logic [DATA_WIDTH-1:0]  act_right;
    logic                   req_switch;

    assign act_valid = i_data_valid[o_active_source];
    assign act_left  = i_data_left[o_active_source*DATA_WIDTH +: DATA_WIDTH];
    assign act_right = i_data_right[o_active_source*DATA_WIDTH +: DATA_WIDTH];

    // Same-source and out-of-range requests are accepted but change nothing.
    assign req_switch = i_select_valid && (i_select != o_active_source)
                        && ({1'b0, i_select} < SEL_LIMIT);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= FADE_IN;
            gain            <= '0;
            pending         <= '0;
            o_active_source <= '0;
            o_select_ready  <= 1'b0;
            o_switching     <= 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (req_switch) begin
                        pending        <= i_select;
                        state          <= FADE_OUT;
                        o_select_ready <= 1'b0;
                        o_switching    <= 1'b1;
                    end
`ifdef MONITOR_SCHEDULER_MUTE_EN
                    else if (i_mute) begin
                        state          <= MUTE_OUT;
                        o_select_ready <= 1'b0;
                        o_switching    <= 1'b1;
                    end
`endif
                end
                FADE_OUT: begin
                    if (act_valid) begin
                        gain <= gain - GAIN_ONE;
                        if (gain == GAIN_ONE) state <= SWAP;
                    end
                end
                SWAP: begin
                    o_active_source <= pending;
                    state           <= FADE_IN;
                end
                FADE_IN: begin
`ifdef MONITOR_SCHEDULER_MUTE_EN
                    if (i_mute) begin
                        state <= MUTE_OUT;
                    end else
`endif
                    if (act_valid) begin
                        gain <= gain + GAIN_ONE;
                        if (gain == GAIN_MAX - GAIN_ONE) begin
                            state          <= PLAY;
                            o_select_ready <= 1'b1;
                            o_switching    <= 1'b0;
                        end
                    end
                end
`ifdef MONITOR_SCHEDULER_MUTE_EN
                MUTE_OUT: begin
                    // A mute taken from FADE_IN at gain 0 has nothing to ramp.
                    if (gain == '0) begin
                        state <= MUTED;
                    end else if (act_valid) begin
                        gain <= gain - GAIN_ONE;
                        if (gain == GAIN_ONE) state <= MUTED;
                    end
                end
                MUTED: begin
                    if (!i_mute) state <= FADE_IN;
                end
`endif
                default: begin
                    state <= FADE_IN;
                end
            endcase
        end
    end

    monitor_gain_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_BITS  (GAIN_BITS)
    ) u_gain (
        .clock        (i_clock),
        .reset_n      (i_reset_n),
        .sample_left  (act_left),
        .sample_right (act_right),
        .sample_valid (act_valid && (state != SWAP)),
        .gain         (gain),
        .data_left    (o_data_left),
        .data_right   (o_data_right),
        .data_valid   (o_data_valid)
    );

endmodule
